// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg: shared definitions for the frame-buffer draw front end.
//   FB_WIDTH / FB_HEIGHT : frame-buffer geometry (160x120)
//   COLOR_BITS           : RGB333 pixel width
//   COORD_BITS           : coordinate input width
//   rgb333_t, fill_state_t, rect_cmd_t, clip_max()
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int FB_WIDTH   = 160;
  localparam int FB_HEIGHT  = 120;
  localparam int COLOR_BITS = 9;
  localparam int COORD_BITS = 8;

  typedef logic [COLOR_BITS-1:0] rgb333_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    FILL,
    DONE
  } fill_state_t;

  typedef struct packed {
    logic [COORD_BITS-1:0] x0;
    logic [COORD_BITS-1:0] y0;
    logic [COORD_BITS-1:0] x1;
    logic [COORD_BITS-1:0] y1;
    rgb333_t               color;
  } rect_cmd_t;

  // Clamp a far corner to the last valid coordinate.
  function automatic logic [COORD_BITS-1:0] clip_max(input logic [COORD_BITS-1:0] v,
                                                     input logic [COORD_BITS-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/vga_rect_walker.sv
// ---------------------------------------------------------------------------
// vga_rect_walker: latches and clips a fill command, flags empty rectangles
// and walks the raster (x innermost) one pixel per advance.
//   clk                 : clock
//   load                : capture x0/y0/x1/y1/color_in (far corner clipped)
//   start               : position the walker on (x0, y0)
//   advance             : step to the next pixel of the raster
//   cur_x, cur_y, color : current fill pixel
//   last                : current pixel is the clipped (x1, y1)
//   empty               : clipped rectangle contains no pixels
// Holds only datapath state, so it carries no reset.
// ---------------------------------------------------------------------------
module vga_rect_walker
  import vga_pkg::*;
(
  input  logic                  clk,
  input  logic                  load,
  input  logic [COORD_BITS-1:0] x0,
  input  logic [COORD_BITS-1:0] y0,
  input  logic [COORD_BITS-1:0] x1,
  input  logic [COORD_BITS-1:0] y1,
  input  logic [COLOR_BITS-1:0] color_in,
  input  logic                  start,
  input  logic                  advance,
  output logic [COORD_BITS-1:0] cur_x,
  output logic [COORD_BITS-1:0] cur_y,
  output logic [COLOR_BITS-1:0] color,
  output logic                  last,
  output logic                  empty
);

  localparam logic [COORD_BITS-1:0] X_MAX = COORD_BITS'(FB_WIDTH - 1);
  localparam logic [COORD_BITS-1:0] Y_MAX = COORD_BITS'(FB_HEIGHT - 1);
  localparam logic [COORD_BITS-1:0] X_LIM = COORD_BITS'(FB_WIDTH);
  localparam logic [COORD_BITS-1:0] Y_LIM = COORD_BITS'(FB_HEIGHT);

  rect_cmd_t             cmd_q, cmd_d;
  logic [COORD_BITS-1:0] cur_x_q, cur_x_d;
  logic [COORD_BITS-1:0] cur_y_q, cur_y_d;

  always_comb begin
    cmd_d = cmd_q;
    if (load) begin
      cmd_d.x0    = x0;
      cmd_d.y0    = y0;
      cmd_d.x1    = clip_max(x1, X_MAX);
      cmd_d.y1    = clip_max(y1, Y_MAX);
      cmd_d.color = color_in;
    end
  end

  // Raster step: wrap x back to x0 and bump y at the end of each row.
  always_comb begin
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    if (start) begin
      cur_x_d = cmd_q.x0;
      cur_y_d = cmd_q.y0;
    end else if (advance) begin
      if (cur_x_q == cmd_q.x1) begin
        cur_x_d = cmd_q.x0;
        cur_y_d = cur_y_q + 1'b1;
      end else begin
        cur_x_d = cur_x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    cmd_q   <= cmd_d;
    cur_x_q <= cur_x_d;
    cur_y_q <= cur_y_d;
  end

  // An origin off-screen is empty even though the clipped far corner is valid.
  assign empty = (cmd_q.x0 > cmd_q.x1) || (cmd_q.y0 > cmd_q.y1) ||
                 (cmd_q.x0 >= X_LIM)   || (cmd_q.y0 >= Y_LIM);
  assign last  = (cur_x_q == cmd_q.x1) && (cur_y_q == cmd_q.y1);
  assign cur_x = cur_x_q;
  assign cur_y = cur_y_q;
  assign color = cmd_q.color;

endmodule

// File: rtl/vga_draw_controller.sv
// ---------------------------------------------------------------------------
// vga_draw_controller: frame-buffer write-port front end. Arbitrates a
// single-pixel port against a rectangle-fill engine, one write per clock.
//   Slow_Clock, Reset_N (async, active-low)
//   Pix_Valid/Pix_Ready, Pix_X, Pix_Y, Pix_Color       : pixel port
//   Rect_Valid/Rect_Ready, Rect_X0..Y1, Rect_Color      : fill command
//   Fill_Busy, Fill_Done                                : fill status
//   Enable_Draw, Draw_X, Draw_Y, Draw_Color             : registered write
// Optional (macro VGA_DRAW_STATS_EN): Draw_Count write counter with
// synchronous Stats_Clear.
// ---------------------------------------------------------------------------
module vga_draw_controller
  import vga_pkg::*;
#(
  parameter int FAIR_LIMIT = 4
) (
  input  logic                  Slow_Clock,
  input  logic                  Reset_N,
  input  logic                  Pix_Valid,
  output logic                  Pix_Ready,
  input  logic [COORD_BITS-1:0] Pix_X,
  input  logic [COORD_BITS-1:0] Pix_Y,
  input  logic [COLOR_BITS-1:0] Pix_Color,
  input  logic                  Rect_Valid,
  output logic                  Rect_Ready,
  input  logic [COORD_BITS-1:0] Rect_X0,
  input  logic [COORD_BITS-1:0] Rect_Y0,
  input  logic [COORD_BITS-1:0] Rect_X1,
  input  logic [COORD_BITS-1:0] Rect_Y1,
  input  logic [COLOR_BITS-1:0] Rect_Color,
  output logic                  Fill_Busy,
  output logic                  Fill_Done,
  output logic                  Enable_Draw,
  output logic [31:0]           Draw_X,
  output logic [31:0]           Draw_Y,
  output logic [31:0]           Draw_Color
`ifdef VGA_DRAW_STATS_EN
  ,
  output logic [31:0]           Draw_Count,
  input  logic                  Stats_Clear
`endif
);

  localparam int FAIR_W = $clog2(FAIR_LIMIT + 1);

  fill_state_t           state_q, state_d;
  logic                  active_q;
  logic [FAIR_W-1:0]     fair_q, fair_d;
  logic                  rr_q, rr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  en_q, en_d;
  logic [COORD_BITS-1:0] dx_q, dx_d;
  logic [COORD_BITS-1:0] dy_q, dy_d;
  rgb333_t               dc_q, dc_d;

  logic                  in_fill, pix_grant, pix_write, fill_write, rect_acc;
  logic [COORD_BITS-1:0] cur_x, cur_y;
  rgb333_t               fill_color;
  logic                  walk_last, walk_empty;

  vga_rect_walker u_walker (
    .clk      (Slow_Clock),
    .load     (rect_acc),
    .x0       (Rect_X0),
    .y0       (Rect_Y0),
    .x1       (Rect_X1),
    .y1       (Rect_Y1),
    .color_in (Rect_Color),
    .start    (state_q == SETUP),
    .advance  (fill_write),
    .cur_x    (cur_x),
    .cur_y    (cur_y),
    .color    (fill_color),
    .last     (walk_last),
    .empty    (walk_empty)
  );

  // Arbitration: the pixel port wins unless it has starved a running fill
  // for FAIR_LIMIT consecutive cycles. active_q keeps Pix_Ready low in reset.
  always_comb begin
    in_fill    = (state_q == FILL);
    pix_grant  = active_q && Pix_Valid &&
                 !(in_fill && (fair_q == FAIR_W'(FAIR_LIMIT)));
    pix_write  = pix_grant && (Pix_X < COORD_BITS'(FB_WIDTH)) &&
                 (Pix_Y < COORD_BITS'(FB_HEIGHT));
    fill_write = in_fill && !pix_grant;
    rect_acc   = (state_q == IDLE) && rr_q && Rect_Valid;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rect_acc) state_d = SETUP;
      SETUP:   state_d = walk_empty ? IDLE : FILL;
      FILL:    if (fill_write && walk_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    done_d = ((state_q == SETUP) && walk_empty) || (fill_write && walk_last);
    busy_d = (state_d != IDLE);
    rr_d   = (state_d == IDLE);

    fair_d = fair_q;
    if (!in_fill || fill_write) fair_d = '0;
    else if (pix_grant)         fair_d = fair_q + 1'b1;

    en_d = pix_write || fill_write;
    dx_d = dx_q;
    dy_d = dy_q;
    dc_d = dc_q;
    if (pix_write) begin
      dx_d = Pix_X;
      dy_d = Pix_Y;
      dc_d = Pix_Color;
    end else if (fill_write) begin
      dx_d = cur_x;
      dy_d = cur_y;
      dc_d = fill_color;
    end
  end

  // ---- grant -> registered write port / status ----
  always_ff @(posedge Slow_Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q  <= IDLE;
      active_q <= 1'b0;
      fair_q   <= '0;
      rr_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
      dx_q     <= '0;
      dy_q     <= '0;
      dc_q     <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
      fair_q   <= fair_d;
      rr_q     <= rr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      en_q     <= en_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      dc_q     <= dc_d;
    end
  end

  assign Pix_Ready   = pix_grant;
  assign Rect_Ready  = rr_q;
  assign Fill_Busy   = busy_q;
  assign Fill_Done   = done_q;
  assign Enable_Draw = en_q;
  assign Draw_X      = {{(32-COORD_BITS){1'b0}}, dx_q};
  assign Draw_Y      = {{(32-COORD_BITS){1'b0}}, dy_q};
  assign Draw_Color  = {{(32-COLOR_BITS){1'b0}}, dc_q};

`ifdef VGA_DRAW_STATS_EN
  logic [31:0] cnt_q, cnt_d;

  // Clear beats increment when both land in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (Stats_Clear)  cnt_d = '0;
    else if (en_q)    cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge Slow_Clock or negedge Reset_N) begin
    if (!Reset_N) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign Draw_Count = cnt_q;
`endif

endmodule

// File: doc/vga_draw_controller.md
Name: vga_draw_controller

Overview:
- Front end of the 160x120x9 frame-buffer write port.
- Arbitrates between two requesters: a single-pixel port (CPU store path) and a rectangle-fill engine (clear screen, boxes, sprite backgrounds).
- Drives the frame-buffer write interface (Enable_Draw, Draw_X, Draw_Y, Draw_Color): at most one pixel write per clock, registered.

Parameters:
- FB_WIDTH, 160, frame-buffer width in pixels.
- FB_HEIGHT, 120, frame-buffer height in pixels.
- COLOR_BITS, 9, pixel colour width (RGB333).
- COORD_BITS, 8, width of coordinate inputs.
- FAIR_LIMIT, 4, max consecutive pixel-port grants while a fill is pending.

Ports:
- Slow_Clock  in  1  sole clock; same domain as the frame-buffer write port.
- Reset_N  in  1  asynchronous, active-low reset.
- Pix_Valid  in  1  single-pixel request.
- Pix_Ready  out  1  pixel request accepted this cycle.
- Pix_X, Pix_Y  in  COORD_BITS each  pixel coordinates.
- Pix_Color  in  COLOR_BITS  pixel colour.
- Rect_Valid  in  1  fill command request.
- Rect_Ready  out  1  fill command accepted this cycle.
- Rect_X0, Rect_Y0, Rect_X1, Rect_Y1  in  COORD_BITS each  inclusive corners.
- Rect_Color  in  COLOR_BITS  fill colour.
- Fill_Busy  out  1  fill in progress.
- Fill_Done  out  1  one-cycle pulse at fill completion.
- Enable_Draw  out  1  frame-buffer write strobe.
- Draw_X, Draw_Y  out  32 each  zero-extended write coordinates.
- Draw_Color  out  32  zero-extended colour.

Behaviour:
- Reset (Reset_N low, asynchronous): FSM to IDLE; all outputs 0; fair counter 0. A fill in progress is abandoned with no Fill_Done.
- FSM states:
  - IDLE: Rect_Ready=1. On Rect_Valid, latch the command, clip and go to SETUP.
  - SETUP: one cycle. If the clipped rect is empty, pulse Fill_Done and return to IDLE; else load cur_x=X0, cur_y=Y0 and go to FILL.
  - FILL: raster walk, x innermost. After writing (X1,Y1), go to DONE.
  - DONE: pulse Fill_Done for one cycle, return to IDLE.
- Clipping: X1 = min(X1, FB_WIDTH-1); Y1 = min(Y1, FB_HEIGHT-1). The rect is empty if X0 > X1, Y0 > Y1, X0 >= FB_WIDTH or Y0 >= FB_HEIGHT. An empty command is still accepted and still produces Fill_Done.
- Pixel port:
  - Pix_Ready is combinational and equals the pixel-port grant.
  - Out-of-range pixels (X >= FB_WIDTH or Y >= FB_HEIGHT) are acked but produce no write.
- Arbitration, per cycle:
  - Outside FILL, the pixel port is always granted.
  - In FILL, the pixel port wins unless the fair counter equals FAIR_LIMIT; then the fill wins that cycle.
  - The fair counter increments on each pixel grant while in FILL, and clears on any fill write or on leaving FILL.
  - A fill cycle without a write (pixel granted) does not advance cur_x/cur_y.
- Output timing:
  - Enable_Draw, Draw_X, Draw_Y and Draw_Color are registered: latency 1 cycle from grant.
  - Enable_Draw=0 in idle cycles. Draw_* hold their last value when not writing.
- Ordering:
  - A pixel write granted in the same cycle a fill is accepted lands before any fill pixel. Pixel writes overlapping a fill region may be overwritten by later fill writes; that is intended.
  - Fill_Busy=1 in SETUP, FILL and DONE.
- Fill throughput: (X1-X0+1)*(Y1-Y0+1) write cycles, plus 2 cycles overhead, plus stall cycles.

Optional Feature:
- Macro: VGA_DRAW_STATS_EN.
- Defined:
  - Adds output Draw_Count [31:0], which counts every Enable_Draw cycle and wraps at 2^32.
  - Adds input Stats_Clear [1], which zeroes the counter synchronously and takes priority over the increment in the same cycle.
  - Draw_Count resets to 0.
- Undefined: neither port nor the counter exists; all other behaviour is identical.

Decomposition:
- Shared package vga_pkg:
  - FB_WIDTH, FB_HEIGHT, COLOR_BITS.
  - typedef rgb333_t.
  - typedef fill_state_t {IDLE, SETUP, FILL, DONE}.
  - struct rect_cmd_t (x0, y0, x1, y1, color).
- Natural sub-module vga_rect_walker: holds the clip, empty detect and the cur_x/cur_y raster counters with advance/last outputs. The top level keeps the FSM, arbiter and output registers.

Test Plan:
- Single pixel (10,20), colour 0x1FF, no fill active -> Pix_Ready=1 same cycle; next cycle Enable_Draw=1, Draw_X=10, Draw_Y=20, Draw_Color=0x1FF.
- Fill (0,0)-(159,119), colour 0 -> exactly 19200 writes in raster order; Fill_Done 19202 cycles after accept; Fill_Busy low after Fill_Done.
- Fill (150,115)-(200,200) -> clipped to (150,115)-(159,119): 50 writes, last write at (159,119).
- Fill (5,5)-(3,9) -> no writes; Fill_Done 2 cycles after accept.
- Fill (0,0)-(3,0) with Pix_Valid held high -> pattern of 4 pixel grants then 1 fill write, repeating; all 4 fill pixels are written; Pix_Ready=0 on the fill cycles.
- Reset_N low mid-fill (after 7 writes) -> Enable_Draw=0 immediately; no Fill_Done; Rect_Ready=1 after reset release.
